// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side endpoint for the MEM stage. It accepts one request at a time over
// a valid/ready handshake, waits WAIT_CYCLES wait states, then does either a
// byte-lane write or a full-word read. The raw aligned 32-bit word comes back
// with a one-cycle rsp_valid pulse. Load byte/halfword extraction and sign
// extension are done by the CPU, not here.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : out-of-range accesses are flagged on err, stores are dropped,
//               and loads return 0.
//   undefined : err stays 0 and addresses alias modulo DEPTH_WORDS.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   req_valid  request present          req_ready  accepting (IDLE only)
//   daddr      byte address ([1:0] ignored)
//   dwdata     store data, lane i = dwdata[8i+7:8i]
//   dwe        byte write enables, 0 = load
//   rsp_valid  one-cycle response pulse
//   rdata      read word (0 for stores), held until the next access
//   stall      pipeline hold request
//   err        out-of-range access, qualified by rsp_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             access;

    // The wrap-around subtraction followed by truncation gives the modulo index.
    assign offset = addr_q - BASE_ADDR;
    assign idx    = IDX_W'(offset >> 2);

`ifdef DMEM_BOUNDS_CHECK_EN
    // 33-bit compare so that a window ending at 2^32 does not wrap.
    assign in_range = (addr_q >= BASE_ADDR) &&
                      ({1'b0, addr_q} < ({1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4));
`else
    assign in_range = 1'b1;
`endif

    // The access fires on the edge that leaves WAIT with cnt==0.
    assign access = (state == WAIT) && (cnt == 4'd0);

    assign req_ready = (state == IDLE);
    assign stall     = (state == WAIT) || ((state == IDLE) && req_valid);

    // The memory array is not reset. A reset on the access edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && access && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            we_q      <= 4'h0;
            rsp_valid <= 1'b0;
            rdata     <= 32'h0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= daddr;
                        wdata_q <= dwdata;
                        we_q    <= dwe;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // A store returns 0. An out-of-range load also reads back as 0.
                        rdata     <= ((we_q == 4'h0) && in_range) ? mem[idx] : 32'h0;
                        err       <= ~in_range;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    err       <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          WC    = 1;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwe = '0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .rsp_valid(rsp_valid),
        .rdata(rdata), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] rd; logic e; } exp_t;
    exp_t q[$];

    logic [31:0] mdl [int];
    int          last_acc = -1000;
    int          prev_acc = -1000;
    logic [31:0] last_rd = '0;
    bit          chk_en = 1'b0;
    bit          keep_valid = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model, written directly from the address-map rules.
    function automatic bit addr_ok(logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a >= BASE) && (longint'(a) < longint'(BASE) + 4 * longint'(DEPTH));
`else
        return 1'b1;
`endif
    endfunction

    function automatic int word_of(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] mdl_rd(int i);
        return mdl.exists(i) ? mdl[i] : 32'h0;
    endfunction

    // Issue one request. commit=0 means the request is expected to be
    // discarded by a reset, so the model and scoreboard are left alone.
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w, input bit commit);
        int   t;
        int   i;
        exp_t x;
        logic [31:0] old;
        t = 0;
        @(negedge clk);
        while (!req_ready) begin
            // While the block is busy, drive junk that it must ignore.
            req_valid = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
            daddr = $urandom; dwdata = $urandom; dwe = 4'($urandom);
            t++;
            if (t > 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b1; daddr = a; dwdata = d; dwe = w;
        if (commit) begin
            i = word_of(a);
            x.e = !addr_ok(a);
            if (w == 4'h0) begin
                x.rd = addr_ok(a) ? mdl_rd(i) : 32'h0;
            end else begin
                x.rd = 32'h0;
                if (addr_ok(a)) begin
                    old = mdl_rd(i);
                    for (int b = 0; b < 4; b++)
                        if (w[b]) old[8*b +: 8] = d[8*b +: 8];
                    mdl[i] = old;
                end
            end
            q.push_back(x);
        end
        if (keep_valid && prev_acc >= 0)
            chk("b2b_period", 32'(cyc + 1 - prev_acc), 32'(WC + 3));
        prev_acc = cyc + 1;
        last_acc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        chk_en = 1'b0;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        last_acc = -1000; prev_acc = -1000; last_rd = '0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk_en = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b0; keep_valid = 1'b0; prev_acc = -1000;
        while ((q.size() != 0 || cyc - last_acc <= WC + 1) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    // Monitor: the expected handshake phase is derived from the accept cycle.
    initial begin
        int   ph;
        bit   ewait, eresp;
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                ph = cyc - last_acc;
                ewait = (ph >= 0) && (ph <= WC);
                eresp = (ph == WC + 1);
                chk("req_ready", 32'(req_ready), 32'(!(ewait || eresp)));
                chk("stall", 32'(stall), 32'(ewait || (!eresp && req_valid)));
                chk("rsp_valid", 32'(rsp_valid), 32'(eresp));
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp actual=1 expected=0 (cycle %0d)", cyc);
                    end else begin
                        x = q.pop_front();
                        chk("rdata", rdata, x.rd);
                        chk("err", 32'(err), 32'(x.e));
                        last_rd = x.rd;
                    end
                end else begin
                    chk("rdata_hold", rdata, last_rd);
                    chk("err_idle", 32'(err), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        repeat (2) @(posedge clk);
        reset_dut();

        // Preload the words the rest of the test reads, so memory contents are known.
        for (int i = 0; i < 16; i++) issue(BASE + 32'(4 * i), $urandom, 4'hF, 1);
        issue(BASE + 32'h200, 32'h0, 4'hF, 1);

        // Full word, byte lane, and ignored low address bits.
        issue(BASE + 32'h100, 32'h1122_3344, 4'hF, 1);
        issue(BASE + 32'h100, 32'h0, 4'h0, 1);
        issue(BASE + 32'h100, 32'h0000_AA00, 4'b0010, 1);
        issue(BASE + 32'h100, 32'h0, 4'h0, 1);
        issue(BASE + 32'h103, 32'h0, 4'h0, 1);
        drain();
        chk("model_byte_lane", mdl_rd(word_of(BASE + 32'h100)), 32'h1122_AA44);

        // Reset in the middle of WAIT, then reset on the access edge.
        keep_valid = 1'b0;
        issue(BASE + 32'h200, 32'hCAFE_F00D, 4'hF, 0);
        chk_en = 1'b0;
        reset_dut();
        issue(BASE + 32'h200, 32'hCAFE_F00D, 4'hF, 0);
        chk_en = 1'b0;
        repeat (WC) @(posedge clk);
        reset_dut();
        issue(BASE + 32'h200, 32'h0, 4'h0, 1);
        drain();

        // Bounds and aliasing. The model gives the expectation for either build.
        issue(BASE + 32'h1000, 32'h55AA_55AA, 4'hF, 1);
        issue(BASE + 32'h0, 32'h0, 4'h0, 1);
        issue(BASE + 32'h1000, 32'h0, 4'h0, 1);
        drain();

        // req_valid held continuously: one accept every WC+3 cycles.
        keep_valid = 1'b1;
        for (int i = 0; i < 6; i++) issue(BASE + 32'(4 * (i % 16)), $urandom, 4'($urandom), 1);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if (n % 25 == 0) begin
                drain();
                keep_valid = 1'($urandom_range(0, 1));
            end
            a = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'(4 * DEPTH);
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            issue(a, $urandom, w, 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
